// File: rtl/gate_arb_pkg.sv
// Shared opcode and FSM encodings for the gate unit arbiter.
package gate_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise gate unit: AND / OR / XOR / NAND of two operands.
module logic_unit
  import gate_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate unit among N_REQ requesters.
// Optional GATE_ARB_CNT_EN adds a saturating 16-bit completed-transaction counter.
module gate_unit_arbiter
  import gate_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       y,
  output logic                   y_valid,
  output logic                   busy
`ifdef GATE_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]       txn_cnt
`endif
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, win_q, win_d, cand;
  logic             win_found;
  op_t              op_q, sel_op;
  logic [WIDTH-1:0] a_q, b_q, sel_a, sel_b, lu_y;

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    win_d     = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_d     = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op = OP_AND;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (IDX_W'(k) == win_d) begin
        sel_op = op_t'(op[2*k +: 2]);
        sel_a  = a_in[WIDTH*k +: WIDTH];
        sel_b  = b_in[WIDTH*k +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      y       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (|req)) begin
        win_q <= win_d;
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
      end
      if (state_q == EXEC) y <= lu_y;
      if (state_q == DONE) ptr_q <= win_q;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q != IDLE) gnt[win_q] = 1'b1;
  end

  assign y_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);

`ifdef GATE_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (state_q == DONE && txn_cnt != '1) begin
      txn_cnt <= txn_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter; counter checks compile only with GATE_ARB_CNT_EN.
module tb_gate_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   gnt;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           busy;
`ifdef GATE_ARB_CNT_EN
  logic [15:0]    txn_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         idx;
    logic [7:0] y;
  } exp_t;
  exp_t sb[$];

  gate_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
`ifdef GATE_ARB_CNT_EN
    ,
    .txn_cnt (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gate_ref(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    op[2*i +: 2]   = o;
    a_in[8*i +: 8] = a;
    b_in[8*i +: 8] = b;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx = i;
    e.y   = gate_ref(op[2*i +: 2], a_in[8*i +: 8], b_in[8*i +: 8]);
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Scoreboard consumer: every y_valid pulse must match the oldest pending transaction.
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: y_valid=1 y=%h, required no pending result", y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (y !== e.y) begin
          errors++;
          $display("FAIL sb_y: got %h required %h (req %0d)", y, e.y, e.idx);
        end
        checks++;
        if (gnt !== 4'(1 << e.idx)) begin
          errors++;
          $display("FAIL sb_gnt: got %b required %b", gnt, 4'(1 << e.idx));
        end
      end
    end
  end

  task automatic test_reset();
    step();
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b required 0000", gnt); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL rst_y: got %h required 00", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid: got %b required 0", y_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
`ifdef GATE_ARB_CNT_EN
    checks++; if (txn_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h required 0000", txn_cnt); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_lane(2, 2'b00, 8'hF0, 8'h3C);
    req = 4'b0100;
    push_exp(2);
    step();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b required 0100", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b required 0", y_valid); end
    step();
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", y_valid); end
    checks++; if (y !== 8'h30) begin errors++; $display("FAIL single_y: got %h required 30", y); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b required 0", busy); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: y_valid=%b required 0", y_valid); end
    checks++; if (y !== 8'h30) begin errors++; $display("FAIL single_hold: got %h required 30", y); end
  endtask

  task automatic test_opcodes();
    logic [7:0] tbl [4];
    tbl = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};
    for (int o = 0; o < 4; o++) begin
      set_lane(0, 2'(o), 8'hAA, 8'h0F);
      req = 4'b0001;
      push_exp(0);
      step();
      req = 4'b0000;
      wait_idle();
      checks++;
      if (y !== tbl[o]) begin errors++; $display("FAIL opcode_%0d: got %h required %h", o, y, tbl[o]); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    for (int i = 0; i < N; i++)
      set_lane(i, 2'(i), 8'h5A ^ 8'(i * 17), 8'hC3 + 8'(i));
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      step();
      exp_gnt = ((c % 3) != 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      checks++;
      if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt c=%0d: got %b required %b", c, gnt, exp_gnt); end
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_latch();
    set_lane(1, 2'b01, 8'h12, 8'h40);
    req = 4'b0010;
    push_exp(1);
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL latch_gnt: got %b required 0010", gnt); end
    set_lane(1, 2'b11, 8'hFF, 8'hFF);
    req = 4'b0000;
    step();
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL latch_valid: got %b required 1", y_valid); end
    wait_idle();
    checks++; if (y !== 8'h52) begin errors++; $display("FAIL latch_y: got %h required 52", y); end
  endtask

  task automatic test_reset_mid();
    set_lane(2, 2'b10, 8'h0F, 8'hFF);
    req = 4'b0100;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_exec: busy=%b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt: got %b required 0000", gnt); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL mid_y: got %h required 00", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", y_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
    req = 4'b0000;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (y_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid c=%0d: got %b required 0", c, y_valid); end
    end
    set_lane(0, 2'b00, 8'hC3, 8'h5A);
    req = 4'b1111;
    push_exp(0);
    step();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_next_gnt: got %b required 0001", gnt); end
    wait_idle();
  endtask

`ifdef GATE_ARB_CNT_EN
  task automatic test_txn_cnt();
    do_reset();
    for (int t = 0; t < 5; t++) begin
      set_lane(3, 2'(t), 8'(t * 29), 8'h66);
      req = 4'b1000;
      push_exp(3);
      step();
      req = 4'b0000;
      wait_idle();
    end
    checks++; if (txn_cnt !== 16'd5) begin errors++; $display("FAIL cnt_five: got %0d required 5", txn_cnt); end
    force dut.txn_cnt = 16'hFFFE;
    #1 release dut.txn_cnt;
    for (int t = 0; t < 2; t++) begin
      req = 4'b1000;
      push_exp(3);
      step();
      req = 4'b0000;
      wait_idle();
    end
    checks++; if (txn_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h required FFFF", txn_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    a_in  = '0;
    b_in  = '0;
    test_reset();
    test_single();
    test_opcodes();
    test_round_robin();
    test_latch();
    test_reset_mid();
`ifdef GATE_ARB_CNT_EN
    test_txn_cnt();
`endif
    step();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d results pending, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
